// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and sizing for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;

    localparam int WRITE_PORTS = 2;
    localparam int REG_AMT     = 16;
    localparam int DATA_W      = 32;
    localparam int ADRS_W      = $clog2(REG_AMT);

    typedef logic [ADRS_W-1:0] t_RFadrs;
    typedef logic [DATA_W-1:0] t_data;

    typedef struct packed {
        logic    valid;
        t_RFadrs dst;
        t_data   data;
    } t_wb_req;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback requester bundle plus the RF write-port side of the arbiter.
interface rf_wb_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int N_WP  = rf_wb_arbiter_pkg::WRITE_PORTS
);
    import rf_wb_arbiter_pkg::*;

    logic    [N_REQ-1:0] req_valid;
    t_RFadrs [N_REQ-1:0] req_dst;
    t_data   [N_REQ-1:0] req_data;
    logic    [N_REQ-1:0] req_ready;

    t_RFadrs [N_WP-1:0]  rf_dst;
    t_data   [N_WP-1:0]  rf_datain;
    logic    [N_WP-1:0]  rf_wr_en;
    logic    [REG_AMT-1:0] pend_mask;

    modport master (
        output req_valid, req_dst, req_data,
        input  req_ready, rf_dst, rf_datain, rf_wr_en, pend_mask
    );

    modport slave (
        input  req_valid, req_dst, req_data,
        output req_ready, rf_dst, rf_datain, rf_wr_en, pend_mask
    );

endinterface

// File: rtl/rf_wb_rr_picker.sv
// Combinational round-robin scan: grants up to N_WP requesters with distinct
// destinations, packing winners onto write ports in scan order.
module rf_wb_rr_picker
    import rf_wb_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int N_WP  = WRITE_PORTS,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic    [N_REQ-1:0]           valid_i,
    input  t_RFadrs [N_REQ-1:0]           dst_i,
    input  logic    [PTR_W-1:0]           rr_ptr_i,
    output logic    [N_REQ-1:0]           grant_o,
    output logic    [N_WP-1:0][PTR_W-1:0] port_sel_o,
    output logic    [N_WP-1:0]            port_vld_o,
    output logic    [PTR_W-1:0]           next_ptr_o
);

    always_comb begin : scan
        int   cnt;
        int   idx;
        logic clash;
        grant_o    = '0;
        port_sel_o = '0;
        port_vld_o = '0;
        next_ptr_o = rr_ptr_i;
        cnt        = 0;
        idx        = 0;
        clash      = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            idx = int'(rr_ptr_i) + j;
            if (idx >= N_REQ) idx = idx - N_REQ;
            // a requester whose dst is already taken this cycle waits for a later cycle
            clash = 1'b0;
            for (int k = 0; k < N_WP; k++) begin
                if (port_vld_o[k] && (dst_i[port_sel_o[k]] == dst_i[idx])) clash = 1'b1;
            end
            if (valid_i[idx] && (cnt < N_WP) && !clash) begin
                grant_o[idx]    = 1'b1;
                port_sel_o[cnt] = PTR_W'(idx);
                port_vld_o[cnt] = 1'b1;
                cnt             = cnt + 1;
                next_ptr_o      = (idx == N_REQ - 1) ? '0 : PTR_W'(idx + 1);
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter: owns rr_ptr, the registered RF write-port
// stage and the pending-write mask.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int N_WP  = WRITE_PORTS
) (
    input  logic            clk,
    input  logic            rst,
    rf_wb_arbiter_if.slave  bus
);

    localparam int PTR_W = $clog2(N_REQ);

    t_wb_req [N_REQ-1:0]           req;
    logic    [N_REQ-1:0]           req_vld;
    t_RFadrs [N_REQ-1:0]           req_dst;
    logic    [N_REQ-1:0]           grant;
    logic    [N_WP-1:0][PTR_W-1:0] port_sel;
    logic    [N_WP-1:0]            port_vld;
    logic    [PTR_W-1:0]           next_ptr;

    logic    [PTR_W-1:0]   rr_ptr_q,  rr_ptr_d;
    logic    [N_WP-1:0]    wr_en_q,   wr_en_d;
    t_RFadrs [N_WP-1:0]    dst_q,     dst_d;
    t_data   [N_WP-1:0]    data_q,    data_d;
    logic    [REG_AMT-1:0] pend_q,    pend_d;

    for (genvar i = 0; i < N_REQ; i++) begin : g_req
        assign req[i]     = '{valid: bus.req_valid[i], dst: bus.req_dst[i], data: bus.req_data[i]};
        assign req_vld[i] = req[i].valid;
        assign req_dst[i] = req[i].dst;
    end

    rf_wb_rr_picker #(
        .N_REQ (N_REQ),
        .N_WP  (N_WP),
        .PTR_W (PTR_W)
    ) u_picker (
        .valid_i    (req_vld),
        .dst_i      (req_dst),
        .rr_ptr_i   (rr_ptr_q),
        .grant_o    (grant),
        .port_sel_o (port_sel),
        .port_vld_o (port_vld),
        .next_ptr_o (next_ptr)
    );

    always_comb begin
        rr_ptr_d = next_ptr;
        wr_en_d  = port_vld;
        dst_d    = dst_q;
        data_d   = data_q;
        pend_d   = '0;
        for (int p = 0; p < N_WP; p++) begin
            if (port_vld[p]) begin
                dst_d[p]  = req[port_sel[p]].dst;
                data_d[p] = req[port_sel[p]].data;
            end
        end
        // pend_mask tracks exactly what the output stage will hold next cycle
        for (int p = 0; p < N_WP; p++) begin
            if (wr_en_d[p]) pend_d[dst_d[p]] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
            wr_en_q  <= '0;
            dst_q    <= '0;
            data_q   <= '0;
            pend_q   <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr_en_q  <= wr_en_d;
            dst_q    <= dst_d;
            data_q   <= data_d;
            pend_q   <= pend_d;
        end
    end

    assign bus.req_ready = grant;
    assign bus.rf_wr_en  = wr_en_q;
    assign bus.rf_dst    = dst_q;
    assign bus.rf_datain = data_q;
    assign bus.pend_mask = pend_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: a 1-port and a 2-port instance, directed scenarios
// plus randomized traffic checked against a scoreboard of issued writes.
module tb_rf_wb_arbiter;
    import rf_wb_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.N_REQ(4), .N_WP(1)) bus1 ();
    rf_wb_arbiter_if #(.N_REQ(4), .N_WP(2)) bus2 ();

    rf_wb_arbiter #(.N_REQ(4), .N_WP(1)) u1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    rf_wb_arbiter #(.N_REQ(4), .N_WP(2)) u2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    // register files fed by the write ports; commit on the edge after the stage loads
    t_data rf1 [REG_AMT];
    t_data rf2 [REG_AMT];

    always @(posedge clk) begin
        if (bus1.rf_wr_en[0]) rf1[bus1.rf_dst[0]] <= bus1.rf_datain[0];
        for (int p = 0; p < 2; p++)
            if (bus2.rf_wr_en[p]) rf2[bus2.rf_dst[p]] <= bus2.rf_datain[p];
    end

    task automatic clr_inputs();
        bus1.req_valid = '0; bus1.req_dst = '0; bus1.req_data = '0;
        bus2.req_valid = '0; bus2.req_dst = '0; bus2.req_data = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clr_inputs();
        #1;
        total++; if (bus1.rf_wr_en !== 1'b0) $display("FAIL reset_wr_en1: got %b want 0", bus1.rf_wr_en); else passed++;
        total++; if (bus1.pend_mask !== '0) $display("FAIL reset_pend1: got %h want 0", bus1.pend_mask); else passed++;
        total++; if (bus1.rf_dst !== '0) $display("FAIL reset_dst1: got %h want 0", bus1.rf_dst); else passed++;
        total++; if (bus2.rf_wr_en !== 2'b00) $display("FAIL reset_wr_en2: got %b want 00", bus2.rf_wr_en); else passed++;
        total++; if (bus2.rf_datain !== '0) $display("FAIL reset_data2: got %h want 0", bus2.rf_datain); else passed++;
        total++; if (u1.rr_ptr_q !== 2'd0) $display("FAIL reset_ptr: got %0d want 0", u1.rr_ptr_q); else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        bus1.req_valid   = 4'b0010;
        bus1.req_dst[1]  = 4'd5;
        bus1.req_data[1] = 32'hA5;
        #1;
        total++; if (bus1.req_ready !== 4'b0010) $display("FAIL single_ready: got %b want 0010", bus1.req_ready); else passed++;
        @(posedge clk); #1;
        bus1.req_valid = '0;
        total++; if (bus1.rf_wr_en !== 1'b1) $display("FAIL single_wr_en: got %b want 1", bus1.rf_wr_en); else passed++;
        total++; if (bus1.rf_dst[0] !== 4'd5) $display("FAIL single_dst: got %0d want 5", bus1.rf_dst[0]); else passed++;
        total++; if (bus1.rf_datain[0] !== 32'hA5) $display("FAIL single_data: got %h want a5", bus1.rf_datain[0]); else passed++;
        total++; if (bus1.pend_mask !== 16'h0020) $display("FAIL single_pend: got %h want 0020", bus1.pend_mask); else passed++;
        @(posedge clk); #1;
        total++; if (rf1[5] !== 32'hA5) $display("FAIL single_rf: got %h want a5", rf1[5]); else passed++;
        total++; if (bus1.rf_wr_en !== 1'b0) $display("FAIL single_idle: got %b want 0", bus1.rf_wr_en); else passed++;
        total++; if (bus1.pend_mask !== '0) $display("FAIL single_pend_clear: got %h want 0", bus1.pend_mask); else passed++;
    endtask

    task automatic test_reset_inflight();
        @(posedge clk); #1;
        bus1.req_valid   = 4'b0001;
        bus1.req_dst[0]  = 4'd5;
        bus1.req_data[0] = 32'h5A;
        @(posedge clk); #1;
        bus1.req_valid = '0;
        total++; if (bus1.rf_wr_en !== 1'b1) $display("FAIL inflight_loaded: got %b want 1", bus1.rf_wr_en); else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if (bus1.rf_wr_en !== 1'b0) $display("FAIL inflight_wr_en: got %b want 0", bus1.rf_wr_en); else passed++;
        total++; if (bus1.pend_mask !== '0) $display("FAIL inflight_pend: got %h want 0", bus1.pend_mask); else passed++;
        total++; if (bus1.rf_dst !== '0) $display("FAIL inflight_dst: got %h want 0", bus1.rf_dst); else passed++;
        total++; if (bus1.rf_datain !== '0) $display("FAIL inflight_data: got %h want 0", bus1.rf_datain); else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (rf1[5] !== 32'hA5) $display("FAIL inflight_rf_kept: got %h want a5", rf1[5]); else passed++;
        total++; if (u1.rr_ptr_q !== 2'd0) $display("FAIL inflight_ptr: got %0d want 0", u1.rr_ptr_q); else passed++;
    endtask

    task automatic test_fairness();
        int e;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            bus1.req_dst[i]  = 4'(8 + i);
            bus1.req_data[i] = 32'(i);
        end
        bus1.req_valid = 4'b1111;
        // ten grants: 0,1,2,3,0,1 then (pointer now 2) 2,3,0,1
        for (int c = 0; c < 10; c++) begin
            e = c % 4;
            #1;
            if (c == 6) begin
                total++; if (u1.rr_ptr_q !== 2'd2) $display("FAIL fair_ptr2: got %0d want 2", u1.rr_ptr_q); else passed++;
            end
            total++; if (bus1.req_ready !== (4'b0001 << e)) $display("FAIL fair_grant c=%0d: got %b want %b", c, bus1.req_ready, 4'b0001 << e); else passed++;
            @(posedge clk); #1;
            total++; if (bus1.rf_wr_en !== 1'b1 || bus1.rf_dst[0] !== 4'(8 + e))
                $display("FAIL fair_port c=%0d: got en=%b dst=%0d want en=1 dst=%0d", c, bus1.rf_wr_en, bus1.rf_dst[0], 8 + e);
            else passed++;
        end
        bus1.req_valid = '0;
    endtask

    task automatic test_conflict();
        @(posedge clk); #1;
        bus2.req_dst[0] = 4'd3; bus2.req_data[0] = 32'h100;
        bus2.req_dst[1] = 4'd3; bus2.req_data[1] = 32'h101;
        bus2.req_dst[2] = 4'd7; bus2.req_data[2] = 32'h102;
        bus2.req_valid  = 4'b0111;
        #1;
        total++; if (bus2.req_ready !== 4'b0101) $display("FAIL conflict_ready1: got %b want 0101", bus2.req_ready); else passed++;
        @(posedge clk); #1;
        total++; if (bus2.rf_wr_en !== 2'b11) $display("FAIL conflict_en1: got %b want 11", bus2.rf_wr_en); else passed++;
        total++; if (bus2.rf_dst[0] !== 4'd3 || bus2.rf_datain[0] !== 32'h100)
            $display("FAIL conflict_port0: got dst=%0d data=%h want dst=3 data=100", bus2.rf_dst[0], bus2.rf_datain[0]);
        else passed++;
        total++; if (bus2.rf_dst[1] !== 4'd7 || bus2.rf_datain[1] !== 32'h102)
            $display("FAIL conflict_port1: got dst=%0d data=%h want dst=7 data=102", bus2.rf_dst[1], bus2.rf_datain[1]);
        else passed++;
        total++; if (bus2.pend_mask !== 16'h0088) $display("FAIL conflict_pend1: got %h want 0088", bus2.pend_mask); else passed++;
        bus2.req_valid = 4'b0010;
        #1;
        total++; if (bus2.req_ready !== 4'b0010) $display("FAIL conflict_ready2: got %b want 0010", bus2.req_ready); else passed++;
        @(posedge clk); #1;
        bus2.req_valid = '0;
        total++; if (bus2.rf_wr_en !== 2'b01) $display("FAIL conflict_en2: got %b want 01", bus2.rf_wr_en); else passed++;
        total++; if (bus2.rf_dst[0] !== 4'd3 || bus2.rf_datain[0] !== 32'h101)
            $display("FAIL conflict_deferred: got dst=%0d data=%h want dst=3 data=101", bus2.rf_dst[0], bus2.rf_datain[0]);
        else passed++;
        total++; if (bus2.pend_mask !== 16'h0008) $display("FAIL conflict_pend2: got %h want 0008", bus2.pend_mask); else passed++;
        @(posedge clk); #1;
        total++; if (rf2[3] !== 32'h101 || rf2[7] !== 32'h102)
            $display("FAIL conflict_rf: got r3=%h r7=%h want r3=101 r7=102", rf2[3], rf2[7]);
        else passed++;
    endtask

    task automatic test_idle_wrap();
        repeat (3) begin
            @(posedge clk); #1;
            total++; if (bus1.rf_wr_en !== 1'b0 || bus1.req_ready !== 4'b0000 || bus1.pend_mask !== '0)
                $display("FAIL idle_outputs: got en=%b rdy=%b pend=%h want 0/0000/0", bus1.rf_wr_en, bus1.req_ready, bus1.pend_mask);
            else passed++;
            total++; if (u1.rr_ptr_q !== 2'd2) $display("FAIL idle_ptr_held: got %0d want 2", u1.rr_ptr_q); else passed++;
        end
        bus1.req_dst[3]  = 4'd2;
        bus1.req_data[3] = 32'h33;
        bus1.req_valid   = 4'b1000;
        #1;
        total++; if (bus1.req_ready !== 4'b1000) $display("FAIL wrap_ready3: got %b want 1000", bus1.req_ready); else passed++;
        @(posedge clk); #1;
        total++; if (u1.rr_ptr_q !== 2'd0) $display("FAIL wrap_ptr: got %0d want 0", u1.rr_ptr_q); else passed++;
        bus1.req_valid = 4'b1111;
        #1;
        total++; if (bus1.req_ready !== 4'b0001) $display("FAIL wrap_next_grant: got %b want 0001", bus1.req_ready); else passed++;
        @(posedge clk); #1;
        bus1.req_valid = '0;
    endtask

    // Requesters issue tagged writes {id, seq}; the scoreboard checks that every
    // accepted write shows up on a port the next cycle, in order, exactly once.
    task automatic test_stress();
        int         seqn [4];
        int         last [4];
        int         issued [4];
        int         written [4];
        int         waitc [4];
        logic [3:0] vld, rdy;
        t_RFadrs    acc_dst [4];
        t_data      acc_dat [4];
        int         acc_n, nd, eg, phase, id, sq;
        logic       uniq, dup, found;
        logic [REG_AMT-1:0] exp_mask;
        logic [1:0] exp_en;
        for (int i = 0; i < 4; i++) begin
            seqn[i] = 0; last[i] = -1; issued[i] = 0; written[i] = 0; waitc[i] = 0;
        end
        bus2.req_valid = '0;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 700; cyc++) begin
            phase = (cyc < 300) ? 0 : ((cyc < 600) ? 1 : 2);
            for (int i = 0; i < 4; i++) begin
                if (!bus2.req_valid[i] && phase != 2 && $urandom_range(3) != 0) begin
                    bus2.req_valid[i] = 1'b1;
                    bus2.req_dst[i]   = (phase == 0) ? 4'(i * 4 + int'($urandom_range(3))) : 4'($urandom_range(2));
                    bus2.req_data[i]  = {8'(i), 24'(seqn[i])};
                    seqn[i]++;
                    issued[i]++;
                end
            end
            #1;
            vld = bus2.req_valid;
            rdy = bus2.req_ready;
            total++; if ((rdy & ~vld) !== 4'b0000) $display("FAIL stress_ready_no_valid cyc=%0d: rdy=%b vld=%b", cyc, rdy, vld); else passed++;
            nd = 0;
            for (int i = 0; i < 4; i++) begin
                dup = 1'b0;
                for (int j = 0; j < i; j++)
                    if (vld[j] && vld[i] && bus2.req_dst[j] == bus2.req_dst[i]) dup = 1'b1;
                if (vld[i] && !dup) nd++;
            end
            eg = (nd < 2) ? nd : 2;
            total++; if ($countones(rdy) != eg) $display("FAIL stress_grant_count cyc=%0d: got %0d want %0d", cyc, $countones(rdy), eg); else passed++;
            uniq = 1'b1;
            for (int i = 0; i < 4; i++)
                for (int j = i + 1; j < 4; j++)
                    if (rdy[i] && rdy[j] && bus2.req_dst[i] == bus2.req_dst[j]) uniq = 1'b0;
            total++; if (uniq !== 1'b1) $display("FAIL stress_grant_dst_unique cyc=%0d: rdy=%b", cyc, rdy); else passed++;
            for (int i = 0; i < 4; i++) begin
                if (phase == 0 && vld[i]) begin
                    waitc[i] = rdy[i] ? 0 : waitc[i] + 1;
                    total++; if (waitc[i] >= 3) $display("FAIL stress_starvation req=%0d: waited %0d want <3", i, waitc[i]); else passed++;
                end else begin
                    waitc[i] = 0;
                end
            end
            acc_n = 0;
            exp_mask = '0;
            for (int i = 0; i < 4; i++) begin
                if (vld[i] && rdy[i]) begin
                    acc_dst[acc_n] = bus2.req_dst[i];
                    acc_dat[acc_n] = bus2.req_data[i];
                    exp_mask[bus2.req_dst[i]] = 1'b1;
                    acc_n++;
                end
            end
            @(posedge clk); #1;
            exp_en = (acc_n == 0) ? 2'b00 : ((acc_n == 1) ? 2'b01 : 2'b11);
            total++; if (bus2.rf_wr_en !== exp_en) $display("FAIL stress_port_enables cyc=%0d: got %b want %b", cyc, bus2.rf_wr_en, exp_en); else passed++;
            total++; if (bus2.pend_mask !== exp_mask) $display("FAIL stress_pend cyc=%0d: got %h want %h", cyc, bus2.pend_mask, exp_mask); else passed++;
            for (int p = 0; p < 2; p++) begin
                if (bus2.rf_wr_en[p]) begin
                    found = 1'b0;
                    for (int k = 0; k < acc_n; k++)
                        if (acc_dst[k] == bus2.rf_dst[p] && acc_dat[k] == bus2.rf_datain[p]) found = 1'b1;
                    total++; if (found !== 1'b1) $display("FAIL stress_write_accepted cyc=%0d port=%0d: dst=%0d data=%h not accepted", cyc, p, bus2.rf_dst[p], bus2.rf_datain[p]); else passed++;
                    id = int'(bus2.rf_datain[p][31:24]);
                    sq = int'(bus2.rf_datain[p][23:0]);
                    total++;
                    if (id >= 4 || sq != last[id] + 1) $display("FAIL stress_order cyc=%0d: id=%0d seq=%0d", cyc, id, sq);
                    else begin passed++; last[id] = sq; written[id]++; end
                end
            end
            if (bus2.rf_wr_en == 2'b11) begin
                total++; if (bus2.rf_dst[0] === bus2.rf_dst[1]) $display("FAIL stress_port_dst_dup cyc=%0d: both ports dst=%0d want distinct", cyc, bus2.rf_dst[0]); else passed++;
            end
            for (int i = 0; i < 4; i++)
                if (vld[i] && rdy[i]) bus2.req_valid[i] = 1'b0;
        end
        total++; if (bus2.req_valid !== 4'b0000) $display("FAIL stress_drain: still pending %b want 0000", bus2.req_valid); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++; if (written[i] != issued[i]) $display("FAIL stress_no_loss req=%0d: written %0d want %0d", i, written[i], issued[i]); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset_inflight();
        test_fairness();
        test_conflict();
        test_idle_wrap();
        test_stress();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
